// File: rtl/data_mem_access_ctrl.sv
// Load/store initiator for dataMemory: byte/half/word access, sign/zero extension, read-modify-write.
// Optional misalignment error response is enabled by defining MEM_ALIGN_CHECK_EN.
module data_mem_access_ctrl #(
   parameter int READ_LAT = 1
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic        reqWrite,
   input  logic [1:0]  reqSize,
   input  logic        reqUnsigned,
   input  logic [31:0] reqAddr,
   input  logic [31:0] reqWData,
   output logic        rspValid,
   output logic [31:0] rspRData,
   output logic        rspErr,
   output logic [31:0] memAddr,
   output logic [31:0] memWriteData,
   output logic        memRead,
   output logic        memWrite,
   output logic        memWriteEnable,
   input  logic [31:0] memReadData,
   output logic [2:0]  dbgState
);
   // Handshake: a request transfers on a rising edge where reqValid && reqReady; reqReady is high
   // only in IDLE (and low while Rst is asserted), so one transaction is in flight at a time.
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RD        = 3'd1,
      S_WR_SETUP  = 3'd2,
      S_WR_COMMIT = 3'd3,
      S_RSP       = 3'd4
   } state_t;

   localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   state_t          r_state;
   state_t          w_next;
   logic            r_write;
   logic [1:0]      r_size;
   logic            r_unsigned;
   logic [31:0]     r_addr;
   logic [31:0]     r_wword;
   logic [31:0]     r_rdata;
   logic            r_err;
   logic [CW-1:0]   r_cnt;
   logic            w_accept;
   logic            w_misaligned;
   logic            w_rd_done;

   function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] lane, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = word[{lane[1], 4'b0000} +: 16];
      case (size)
         2'b00:   f_extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   f_extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: f_extract = word;
      endcase
   endfunction

   function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [15:0] data,
                                           input logic [1:0] size, input logic [1:0] lane);
      logic [31:0] m;
      m = word;
      if (size == 2'b00) m[{lane, 3'b000} +: 8] = data[7:0];
      else               m[{lane[1], 4'b0000} +: 16] = data;
      return m;
   endfunction

   assign w_accept  = reqValid && reqReady;
   assign w_rd_done = (r_state == S_RD) && (r_cnt == CW'(READ_LAT - 1));

`ifdef MEM_ALIGN_CHECK_EN
   assign w_misaligned = ((reqSize == 2'b01) && reqAddr[0]) ||
                         (reqSize[1] && (reqAddr[1:0] != 2'b00));
`else
   assign w_misaligned = 1'b0;
`endif

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_misaligned)                w_next = S_RSP;
               else if (reqWrite && reqSize[1]) w_next = S_WR_SETUP;
               else                             w_next = S_RD;
            end
         end
         S_RD:        if (w_rd_done) w_next = r_write ? S_WR_SETUP : S_RSP;
         S_WR_SETUP:  w_next = S_WR_COMMIT;
         S_WR_COMMIT: w_next = S_RSP;
         S_RSP:       w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_comb begin
      reqReady       = (r_state == S_IDLE) && !Rst;
      memRead        = (r_state == S_RD);
      memWrite       = (r_state == S_WR_SETUP) || (r_state == S_WR_COMMIT);
      memWriteEnable = (r_state == S_WR_COMMIT);
      rspValid       = (r_state == S_RSP);
      rspRData       = (r_state == S_RSP) ? r_rdata : 32'h0;
      rspErr         = (r_state == S_RSP) && r_err;
      memAddr        = (r_state == S_IDLE) ? 32'h0 : {2'b00, r_addr[31:2]};
      memWriteData   = (r_state == S_IDLE) ? 32'h0 : r_wword;
      dbgState       = r_state;
   end

   // Sub-word stores reuse the RD phase; the merged word replaces the right-justified store data.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_write    <= 1'b0;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_addr     <= 32'h0;
         r_wword    <= 32'h0;
         r_rdata    <= 32'h0;
         r_err      <= 1'b0;
         r_cnt      <= '0;
      end else if (w_accept) begin
         r_write    <= reqWrite;
         r_size     <= reqSize;
         r_unsigned <= reqUnsigned;
         r_addr     <= reqAddr;
         r_wword    <= reqWrite ? reqWData : 32'h0;
         r_rdata    <= 32'h0;
         r_err      <= w_misaligned;
         r_cnt      <= '0;
      end else if (r_state == S_RD) begin
         if (!w_rd_done)   r_cnt   <= r_cnt + CW'(1);
         else if (r_write) r_wword <= f_merge(memReadData, r_wword[15:0], r_size, r_addr[1:0]);
         else              r_rdata <= f_extract(memReadData, r_size, r_addr[1:0], r_unsigned);
      end
   end
endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Directed bench for data_mem_access_ctrl (READ_LAT=1) with a small word-addressed memory model.
// Misaligned-access expectations follow MEM_ALIGN_CHECK_EN when it is defined for the build.
module tb_data_mem_access_ctrl;
   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        reqValid = 1'b0;
   logic        reqReady;
   logic        reqWrite = 1'b0;
   logic [1:0]  reqSize = 2'b00;
   logic        reqUnsigned = 1'b0;
   logic [31:0] reqAddr = 32'h0;
   logic [31:0] reqWData = 32'h0;
   logic        rspValid;
   logic [31:0] rspRData;
   logic        rspErr;
   logic [31:0] memAddr;
   logic [31:0] memWriteData;
   logic        memRead;
   logic        memWrite;
   logic        memWriteEnable;
   logic [31:0] memReadData;
   logic [2:0]  dbgState;

   int n_tests = 0;
   int n_fail  = 0;
   int rsp_cnt = 0;

   logic [7:0]  g_rd, g_wr, g_we, g_rsp;
   logic [31:0] g_rdata, g_maddr;
   logic        g_err, g_overlap, g_maddr_bad, g_seen, g_ready0;

   logic [31:0] mem [0:15];

   data_mem_access_ctrl #(.READ_LAT(1)) dut (
      .Clk(Clk), .Rst(Rst), .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
      .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqAddr(reqAddr), .reqWData(reqWData),
      .rspValid(rspValid), .rspRData(rspRData), .rspErr(rspErr), .memAddr(memAddr),
      .memWriteData(memWriteData), .memRead(memRead), .memWrite(memWrite),
      .memWriteEnable(memWriteEnable), .memReadData(memReadData), .dbgState(dbgState)
   );

   always #5 Clk = ~Clk;

   assign memReadData = mem[memAddr[3:0]];
   always @(posedge Clk) if (memWrite && memWriteEnable) mem[memAddr[3:0]] <= memWriteData;
   always @(negedge Clk) if (rspValid) rsp_cnt++;

   // Issues one request from IDLE and records strobes for the six cycles after acceptance (bit c = cycle c).
   task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
      @(negedge Clk);
      reqValid = 1'b1; reqWrite = wr; reqSize = sz; reqUnsigned = uns; reqAddr = addr; reqWData = wd;
      g_ready0 = reqReady;
      g_rd = '0; g_wr = '0; g_we = '0; g_rsp = '0; g_rdata = '0; g_err = 1'b0;
      g_maddr = '0; g_overlap = 1'b0; g_maddr_bad = 1'b0; g_seen = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge Clk);
         reqValid = 1'b0;
         if (memRead)        g_rd[c] = 1'b1;
         if (memWrite)       g_wr[c] = 1'b1;
         if (memWriteEnable) g_we[c] = 1'b1;
         if (memRead && memWrite) g_overlap = 1'b1;
         if (memRead || memWrite) begin
            if (g_seen && memAddr !== g_maddr) g_maddr_bad = 1'b1;
            g_maddr = memAddr; g_seen = 1'b1;
         end
         if (rspValid) begin g_rsp[c] = 1'b1; g_rdata = rspRData; g_err = rspErr; end
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge Clk);
      n_tests++; if (reqReady !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", reqReady); end
      n_tests++; if ({memRead, memWrite, memWriteEnable, rspValid, rspErr} !== 5'b0) begin
         n_fail++; $display("FAIL rst_strobes got=%b exp=00000", {memRead, memWrite, memWriteEnable, rspValid, rspErr}); end
      n_tests++; if ({memAddr, memWriteData, rspRData} !== 96'h0) begin
         n_fail++; $display("FAIL rst_buses got=%h %h %h exp=0", memAddr, memWriteData, rspRData); end
      Rst = 1'b0;
      #1;
      n_tests++; if (reqReady !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got=%b exp=1", reqReady); end
   endtask

   task automatic test_word_store_load;
      run_req(1'b1, 2'b10, 1'b0, 32'h0000_000C, 32'hDEAD_BEEF);
      n_tests++; if (g_ready0 !== 1'b1) begin n_fail++; $display("FAIL sw_ready got=%b exp=1", g_ready0); end
      n_tests++; if ({g_rd, g_wr, g_we, g_rsp} !== {8'h00, 8'h06, 8'h04, 8'h08}) begin
         n_fail++; $display("FAIL sw_timing got=%h/%h/%h/%h exp=00/06/04/08", g_rd, g_wr, g_we, g_rsp); end
      n_tests++; if (g_maddr !== 32'd3 || g_maddr_bad) begin
         n_fail++; $display("FAIL sw_addr got=%h unstable=%b exp=00000003", g_maddr, g_maddr_bad); end
      n_tests++; if (mem[3] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[3]); end
      n_tests++; if (g_rdata !== 32'h0 || g_err !== 1'b0) begin
         n_fail++; $display("FAIL sw_rsp got=%h err=%b exp=0 err=0", g_rdata, g_err); end
      run_req(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0);
      n_tests++; if ({g_rd, g_wr, g_we, g_rsp} !== {8'h02, 8'h00, 8'h00, 8'h04}) begin
         n_fail++; $display("FAIL lw_timing got=%h/%h/%h/%h exp=02/00/00/04", g_rd, g_wr, g_we, g_rsp); end
      n_tests++; if (g_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_data got=%h exp=deadbeef", g_rdata); end
      run_req(1'b0, 2'b11, 1'b1, 32'h0000_000C, 32'h0);
      n_tests++; if (g_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_size3 got=%h exp=deadbeef", g_rdata); end
   endtask

   task automatic test_subword;
      run_req(1'b1, 2'b00, 1'b0, 32'h0000_000D, 32'hFFFF_FFA5);
      n_tests++; if ({g_rd, g_wr, g_we, g_rsp} !== {8'h02, 8'h0C, 8'h08, 8'h10}) begin
         n_fail++; $display("FAIL sb_timing got=%h/%h/%h/%h exp=02/0c/08/10", g_rd, g_wr, g_we, g_rsp); end
      n_tests++; if (g_overlap !== 1'b0 || g_maddr_bad !== 1'b0) begin
         n_fail++; $display("FAIL sb_overlap got=%b addr_unstable=%b exp=0 0", g_overlap, g_maddr_bad); end
      n_tests++; if (mem[3] !== 32'hDEAD_A5EF) begin n_fail++; $display("FAIL sb_mem got=%h exp=deada5ef", mem[3]); end
      run_req(1'b0, 2'b00, 1'b0, 32'h0000_000D, 32'h0);
      n_tests++; if (g_rdata !== 32'hFFFF_FFA5) begin n_fail++; $display("FAIL lb_signed got=%h exp=ffffffa5", g_rdata); end
      run_req(1'b0, 2'b00, 1'b1, 32'h0000_000D, 32'h0);
      n_tests++; if (g_rdata !== 32'h0000_00A5) begin n_fail++; $display("FAIL lbu got=%h exp=000000a5", g_rdata); end
      run_req(1'b0, 2'b01, 1'b0, 32'h0000_000E, 32'h0);
      n_tests++; if (g_rdata !== 32'hFFFF_DEAD) begin n_fail++; $display("FAIL lh_signed got=%h exp=ffffdead", g_rdata); end
      run_req(1'b0, 2'b01, 1'b1, 32'h0000_000C, 32'h0);
      n_tests++; if (g_rdata !== 32'h0000_A5EF) begin n_fail++; $display("FAIL lhu got=%h exp=0000a5ef", g_rdata); end
      run_req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1122_3344);
      run_req(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_BEEF);
      n_tests++; if (mem[4] !== 32'hBEEF_3344) begin n_fail++; $display("FAIL sh_mem got=%h exp=beef3344", mem[4]); end
      run_req(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_007F);
      n_tests++; if (mem[4] !== 32'h7FEF_3344) begin n_fail++; $display("FAIL sb3_mem got=%h exp=7fef3344", mem[4]); end
      run_req(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0);
      n_tests++; if (g_rdata !== 32'h0000_007F) begin n_fail++; $display("FAIL lb_pos got=%h exp=0000007f", g_rdata); end
      run_req(1'b0, 2'b00, 1'b1, 32'h0000_0012, 32'h0);
      n_tests++; if (g_rdata !== 32'h0000_00EF) begin n_fail++; $display("FAIL lbu2 got=%h exp=000000ef", g_rdata); end
      run_req(1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0);
      n_tests++; if (g_rdata !== 32'h0000_3344) begin n_fail++; $display("FAIL lh_pos got=%h exp=00003344", g_rdata); end
   endtask

   task automatic test_reset_mid_write;
      int cnt0;
      @(negedge Clk);
      reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b10; reqUnsigned = 1'b0;
      reqAddr = 32'h0000_000C; reqWData = 32'h1234_5678;
      @(negedge Clk);
      reqValid = 1'b0;
      n_tests++; if ({memWrite, memWriteEnable} !== 2'b10) begin
         n_fail++; $display("FAIL rw_setup got=%b exp=10", {memWrite, memWriteEnable}); end
      cnt0 = rsp_cnt;
      #1 Rst = 1'b1;
      #1;
      n_tests++; if ({memRead, memWrite, memWriteEnable} !== 3'b000) begin
         n_fail++; $display("FAIL rw_async_drop got=%b exp=000", {memRead, memWrite, memWriteEnable}); end
      repeat (2) @(negedge Clk);
      n_tests++; if (reqReady !== 1'b0) begin n_fail++; $display("FAIL rw_ready_in_rst got=%b exp=0", reqReady); end
      Rst = 1'b0;
      #1;
      n_tests++; if (reqReady !== 1'b1) begin n_fail++; $display("FAIL rw_ready_after got=%b exp=1", reqReady); end
      repeat (3) @(negedge Clk);
      n_tests++; if (rsp_cnt !== cnt0) begin n_fail++; $display("FAIL rw_no_rsp got=%0d exp=%0d", rsp_cnt, cnt0); end
      n_tests++; if (mem[3] !== 32'hDEAD_A5EF) begin n_fail++; $display("FAIL rw_mem got=%h exp=deada5ef", mem[3]); end
   endtask

   task automatic test_back_to_back;
      logic [7:0]  acc_mask, rsp_mask;
      logic [31:0] last_data;
      acc_mask = '0; rsp_mask = '0; last_data = '0;
      @(negedge Clk);
      reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b10; reqUnsigned = 1'b0; reqAddr = 32'h0000_000C;
      for (int n = 0; n <= 5; n++) begin
         if (n > 0) @(negedge Clk);
         if (reqValid && reqReady) acc_mask[n] = 1'b1;
         if (rspValid) begin rsp_mask[n] = 1'b1; last_data = rspRData; end
      end
      reqValid = 1'b0;
      @(negedge Clk);
      n_tests++; if (acc_mask !== 8'h09) begin n_fail++; $display("FAIL b2b_accepts got=%h exp=09", acc_mask); end
      n_tests++; if (rsp_mask !== 8'h24) begin n_fail++; $display("FAIL b2b_rsps got=%h exp=24", rsp_mask); end
      n_tests++; if (last_data !== 32'hDEAD_A5EF) begin n_fail++; $display("FAIL b2b_data got=%h exp=deada5ef", last_data); end
   endtask

   task automatic test_misaligned;
      run_req(1'b0, 2'b10, 1'b0, 32'h0000_000E, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
      n_tests++; if ({g_rd, g_wr, g_rsp} !== {8'h00, 8'h00, 8'h02}) begin
         n_fail++; $display("FAIL mis_timing got=%h/%h/%h exp=00/00/02", g_rd, g_wr, g_rsp); end
      n_tests++; if (g_err !== 1'b1 || g_rdata !== 32'h0) begin
         n_fail++; $display("FAIL mis_rsp got=err%b %h exp=err1 00000000", g_err, g_rdata); end
`else
      n_tests++; if ({g_rd, g_wr, g_rsp} !== {8'h02, 8'h00, 8'h04}) begin
         n_fail++; $display("FAIL mis_timing got=%h/%h/%h exp=02/00/04", g_rd, g_wr, g_rsp); end
      n_tests++; if (g_err !== 1'b0 || g_rdata !== 32'hDEAD_A5EF) begin
         n_fail++; $display("FAIL mis_rsp got=err%b %h exp=err0 deada5ef", g_err, g_rdata); end
`endif
   endtask

   initial begin
      test_reset();
      test_word_store_load();
      test_subword();
      test_reset_mid_write();
      test_back_to_back();
      test_misaligned();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
